// File: rtl/rotary_input_filter.sv
// Rotary encoder input conditioning: 2-flop synchronisers plus per-channel
// debounce FSMs for quadrature pins A/B, with change pulses and a dual-step flag.
// Optional push switch channel enabled by defining ROTARY_PUSH_EN.

module rotary_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic flip_c
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

  logic [1:0]       sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;

  // Two-flop synchroniser; only the second stage is observed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], raw_i};
  end

  // Debounce state, counter and committed level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Accept a new level only after it differs for DEBOUNCE_CYCLES+1 samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    flip_c  = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync_q[1] != out_q) begin
          state_d = ST_COUNTING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_COUNTING: begin
        if (sync_q[1] == out_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          out_d   = ~out_q;
          flip_c  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = out_q;

endmodule

module rotary_input_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic rot_a_raw,
  input  logic rot_b_raw,
  output logic rot_a,
  output logic rot_b,
  output logic edge_a,
  output logic edge_b,
  output logic dual_step
`ifdef ROTARY_PUSH_EN
  ,
  input  logic rot_push_raw,
  output logic push_pressed
`endif
);

  // Counter must be able to hold DEBOUNCE_CYCLES without wrapping.
  if (DEBOUNCE_CYCLES < 1 || 64'(DEBOUNCE_CYCLES) >= (64'(1) << CNT_W)) begin : g_bad_cfg
    $error("rotary_input_filter: DEBOUNCE_CYCLES must be in 1 .. 2**CNT_W-1");
  end

  logic flip_a_c, flip_b_c;
  logic edge_a_q, edge_b_q, dual_q;

  rotary_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ch_a (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (rot_a_raw),
    .level_o (rot_a),
    .flip_c  (flip_a_c)
  );

  rotary_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ch_b (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (rot_b_raw),
    .level_o (rot_b),
    .flip_c  (flip_b_c)
  );

  // Change pulses aligned with the first cycle the new level is visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_a_q <= 1'b0;
      edge_b_q <= 1'b0;
      dual_q   <= 1'b0;
    end else begin
      edge_a_q <= flip_a_c;
      edge_b_q <= flip_b_c;
      dual_q   <= flip_a_c & flip_b_c;
    end
  end

  assign edge_a    = edge_a_q;
  assign edge_b    = edge_b_q;
  assign dual_step = dual_q;

`ifdef ROTARY_PUSH_EN
  // Pin is active-low; invert so the reset level 0 means "released".
  logic push_level, push_flip_c, push_q;

  rotary_debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ch_push (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (~rot_push_raw),
    .level_o (push_level),
    .flip_c  (push_flip_c)
  );

  // Pulse only on the released-to-pressed transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) push_q <= 1'b0;
    else       push_q <= push_flip_c & ~push_level;
  end

  assign push_pressed = push_q;
`endif

endmodule

// File: tb/tb_rotary_input_filter.sv
module tb_rotary_input_filter;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic reset;
  logic rot_a_raw, rot_b_raw, push_pin;
  logic rot_a, rot_b, edge_a, edge_b, dual_step;
`ifdef ROTARY_PUSH_EN
  logic push_pressed;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rotary_input_filter #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rot_a_raw    (rot_a_raw),
    .rot_b_raw    (rot_b_raw),
    .rot_a        (rot_a),
    .rot_b        (rot_b),
    .edge_a       (edge_a),
    .edge_b       (edge_b),
    .dual_step    (dual_step)
`ifdef ROTARY_PUSH_EN
    ,
    .rot_push_raw (push_pin),
    .push_pressed (push_pressed)
`endif
  );

  // Reference model: raw is delayed two samples, then a level is accepted once
  // it has disagreed with the committed level on D+1 consecutive clock edges.
  logic [2:0] ms1, ms2, mout, medge;
  int         mrun [3];
  logic       mdual, mpush;

  task automatic model_reset();
    ms1 = '0; ms2 = '0; mout = '0; medge = '0;
    mdual = 1'b0; mpush = 1'b0;
    for (int c = 0; c < 3; c++) mrun[c] = 0;
  endtask

  task automatic model_step(input logic [2:0] raw);
    for (int c = 0; c < 3; c++) begin
      medge[c] = 1'b0;
      if (ms2[c] != mout[c]) begin
        mrun[c] = mrun[c] + 1;
        if (mrun[c] == int'(D) + 1) begin
          mout[c]  = ~mout[c];
          mrun[c]  = 0;
          medge[c] = 1'b1;
        end
      end else begin
        mrun[c] = 0;
      end
    end
    ms2   = ms1;
    ms1   = raw;
    mdual = medge[0] & medge[1];
    mpush = medge[2] & mout[2];
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance model with current inputs, then compare after the edge.
  task automatic tick();
    model_step({~push_pin, rot_b_raw, rot_a_raw});
    @(posedge clk);
    #1;
    check("rot_a", int'(rot_a), int'(mout[0]));
    check("rot_b", int'(rot_b), int'(mout[1]));
    check("edge_a", int'(edge_a), int'(medge[0]));
    check("edge_b", int'(edge_b), int'(medge[1]));
    check("dual_step", int'(dual_step), int'(mdual));
`ifdef ROTARY_PUSH_EN
    check("push_pressed", int'(push_pressed), int'(mpush));
`endif
  endtask

  typedef struct {
    logic a;
    logic b;
    int   hold;
    int   lat;     // clocks after sampling edge until outputs change, -1 = never
    logic ra;
    logic rb;
    int   nedge;   // cycles with any edge pulse
    int   ndual;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [1:0] prev;
    int first, nedge, ndual, npush;

    vecs[0] = '{1'b1, 1'b0, 10,  6, 1'b1, 1'b0, 1, 0};
    vecs[1] = '{1'b1, 1'b1, 10,  6, 1'b1, 1'b1, 1, 0};
    vecs[2] = '{1'b0, 1'b1, 10,  6, 1'b0, 1'b1, 1, 0};
    vecs[3] = '{1'b0, 1'b0, 10,  6, 1'b0, 1'b0, 1, 0};
    vecs[4] = '{1'b1, 1'b0,  3, -1, 1'b0, 1'b0, 0, 0};
    vecs[5] = '{1'b0, 1'b0, 10, -1, 1'b0, 1'b0, 0, 0};
    vecs[6] = '{1'b1, 1'b1, 10,  6, 1'b1, 1'b1, 1, 1};
    vecs[7] = '{1'b0, 1'b0, 10,  6, 1'b0, 1'b0, 1, 1};

    reset = 1'b1; rot_a_raw = 1'b0; rot_b_raw = 1'b0; push_pin = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rot_a", int'(rot_a), 0);
    check("reset_rot_b", int'(rot_b), 0);
    check("reset_edge_a", int'(edge_a), 0);
    check("reset_edge_b", int'(edge_b), 0);
    check("reset_dual", int'(dual_step), 0);
    reset = 1'b0;

    // Table: detent sequence, short bounce, simultaneous changes.
    for (int i = 0; i < 8; i++) begin
      prev = {rot_b, rot_a}; first = -1; nedge = 0; ndual = 0;
      rot_a_raw = vecs[i].a;
      rot_b_raw = vecs[i].b;
      for (int k = 1; k <= vecs[i].hold; k++) begin
        tick();
        if (first < 0 && {rot_b, rot_a} != prev) first = k - 1;
        if (edge_a | edge_b) nedge++;
        if (dual_step) ndual++;
      end
      check($sformatf("vec%0d_latency", i), first, vecs[i].lat);
      check($sformatf("vec%0d_rot_a", i), int'(rot_a), int'(vecs[i].ra));
      check($sformatf("vec%0d_rot_b", i), int'(rot_b), int'(vecs[i].rb));
      check($sformatf("vec%0d_edges", i), nedge, vecs[i].nedge);
      check($sformatf("vec%0d_dual", i), ndual, vecs[i].ndual);
    end

    // Reset while the A counter is at 3 with rot_b already high.
    rot_b_raw = 1'b1;
    repeat (10) tick();
    check("pre_reset_rot_b", int'(rot_b), 1);
    rot_a_raw = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("midreset_rot_a", int'(rot_a), 0);
    check("midreset_rot_b", int'(rot_b), 0);
    check("midreset_edges", int'(edge_a | edge_b | dual_step), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (first < 0 && rot_a) first = k - 1;
    end
    check("post_reset_latency", first, 6);

`ifdef ROTARY_PUSH_EN
    // Press produces one pulse; release produces none.
    push_pin = 1'b0; first = -1; npush = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (push_pressed) begin
        npush++;
        if (first < 0) first = k - 1;
      end
    end
    check("push_latency", first, 6);
    check("push_pulses", npush, 1);
    push_pin = 1'b1; npush = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (push_pressed) npush++;
    end
    check("release_pulses", npush, 0);
`else
    npush = 0;
`endif

    // Random levels with varied hold times, checked every cycle by the model.
    for (int s = 0; s < 300; s++) begin
      rot_a_raw = 1'($urandom);
      rot_b_raw = 1'($urandom);
      push_pin  = 1'($urandom);
      repeat ($urandom_range(1, 9)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
